// File: rtl/bic_pkg.sv
// Shared definitions for the bus-invert-coded transmit arbiter.
// Optional statistics are enabled with the BIC_STATS_EN macro.
package bic_pkg;

    localparam int unsigned BIC_WIDTH = 8;
    localparam int unsigned SAV_W     = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bic_state_e;

endpackage

// File: rtl/bic_invert_decide.sv
// Combinational bus-invert decision: Hamming distance of the new word against
// the word last driven, inverted when more than half of the lines would toggle.
module bic_invert_decide
    import bic_pkg::*;
#(
    parameter int unsigned WIDTH = BIC_WIDTH,
    parameter int unsigned HW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] prev_i,
    output logic [WIDTH-1:0] coded_o,
    output logic             inv_o,
    output logic [HW-1:0]    ham_o
);

    logic [WIDTH-1:0] diff;

    assign diff = data_i ^ prev_i;

    always_comb begin
        ham_o = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            ham_o = ham_o + HW'(diff[i]);
        end
    end

    // Exactly half toggling does not invert.
    assign inv_o   = (ham_o > HW'(WIDTH / 2));
    assign coded_o = inv_o ? ~data_i : data_i;

endmodule

// File: rtl/bic_tx_arbiter.sv
// Round-robin two-requester arbiter feeding one registered bus-invert-coded link.
// Define BIC_STATS_EN to add the saturating sav_count transition-savings counter.
module bic_tx_arbiter
    import bic_pkg::*;
#(
    parameter int unsigned WIDTH = BIC_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_inv,
    output logic             bus_valid,
    output logic             bus_src,
    input  logic             bus_ready
`ifdef BIC_STATS_EN
   ,output logic [SAV_W-1:0] sav_count
`endif
);

    localparam int unsigned HW = $clog2(WIDTH + 1);

    bic_state_e       state_q, state_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             bus_inv_q, bus_inv_d;
    logic             bus_src_q, bus_src_d;
    logic             last_grant_q, last_grant_d;

    logic             any_valid;
    logic             winner;
    logic             can_load;
    logic             accept;
    logic [WIDTH-1:0] win_data;
    logic [WIDTH-1:0] coded;
    logic             inv;
    logic [HW-1:0]    ham;

    assign any_valid = req0_valid | req1_valid;
    assign winner    = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign can_load  = (state_q == EMPTY) | bus_ready;
    // Gated by rst so readies drop the instant reset asserts.
    assign accept    = any_valid & can_load & rst;
    assign win_data  = winner ? req1_data : req0_data;

    assign req0_ready = accept & ~winner;
    assign req1_ready = accept & winner;

    // bus_data_q doubles as the previous-driven word, since it holds across idle cycles.
    bic_invert_decide #(
        .WIDTH (WIDTH),
        .HW    (HW)
    ) u_decide (
        .data_i  (win_data),
        .prev_i  (bus_data_q),
        .coded_o (coded),
        .inv_o   (inv),
        .ham_o   (ham)
    );

    always_comb begin
        state_d      = state_q;
        bus_data_d   = bus_data_q;
        bus_inv_d    = bus_inv_q;
        bus_src_d    = bus_src_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            state_d      = FULL;
            bus_data_d   = coded;
            bus_inv_d    = inv;
            bus_src_d    = winner;
            last_grant_d = winner;
        end else if ((state_q == FULL) && bus_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= EMPTY;
            bus_data_q   <= '0;
            bus_inv_q    <= 1'b0;
            bus_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            bus_data_q   <= bus_data_d;
            bus_inv_q    <= bus_inv_d;
            bus_src_q    <= bus_src_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign bus_data  = bus_data_q;
    assign bus_inv   = bus_inv_q;
    assign bus_valid = (state_q == FULL);
    assign bus_src   = bus_src_q;

`ifdef BIC_STATS_EN
    logic [SAV_W-1:0] sav_count_q, sav_count_d;
    logic [SAV_W:0]   sav_sum;

    localparam logic [SAV_W:0] W_EXT = (SAV_W + 1)'(WIDTH);

    // Inversion only happens for H > WIDTH/2, so 2H - WIDTH is always positive.
    assign sav_sum = {1'b0, sav_count_q} + {{(SAV_W - HW){1'b0}}, ham, 1'b0} - W_EXT;

    always_comb begin
        sav_count_d = sav_count_q;
        if (accept && inv) begin
            sav_count_d = sav_sum[SAV_W] ? '1 : sav_sum[SAV_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sav_count_q <= '0;
        end else begin
            sav_count_q <= sav_count_d;
        end
    end

    assign sav_count = sav_count_q;
`else
    logic unused_ham;
    assign unused_ham = ^ham;
`endif

endmodule

// File: tb/tb_bic_tx_arbiter.sv
// Self-checking bench for bic_tx_arbiter: vector table, corner sequences and
// randomized traffic against a behavioural model. Works with or without BIC_STATS_EN.
module tb_bic_tx_arbiter;

    logic       clk;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic [7:0] req0_data, req1_data;
    logic       req0_ready, req1_ready;
    logic [7:0] bus_data;
    logic       bus_inv, bus_valid, bus_src;
    logic       bus_ready;
`ifdef BIC_STATS_EN
    logic [15:0] sav_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    logic s_r0, s_r1;

    // Behavioural model state
    logic       m_bv, m_bi, m_src, m_last, m_r0, m_r1;
    logic [7:0] m_bd;
    int         m_sav;

    bic_tx_arbiter #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .bus_data   (bus_data),
        .bus_inv    (bus_inv),
        .bus_valid  (bus_valid),
        .bus_src    (bus_src),
        .bus_ready  (bus_ready)
`ifdef BIC_STATS_EN
       ,.sav_count  (sav_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_bv = 0; m_bd = '0; m_bi = 0; m_src = 0; m_last = 1; m_sav = 0;
    endtask

    // Computes expected readies from the current model state, then advances it.
    task automatic model_step(input logic v0, input logic [7:0] d0,
                              input logic v1, input logic [7:0] d1, input logic br);
        logic       can, w, any;
        logic [7:0] data;
        int         h;
        any  = v0 | v1;
        can  = !m_bv || br;
        w    = (v0 && v1) ? !m_last : v1;
        m_r0 = any && can && !w;
        m_r1 = any && can && w;
        if (any && can) begin
            data = w ? d1 : d0;
            h    = $countones(data ^ m_bd);
            if (h > 4) begin
                m_bd  = ~data;
                m_bi  = 1;
                m_sav = (m_sav + 2 * h - 8 > 65535) ? 65535 : m_sav + 2 * h - 8;
            end else begin
                m_bd = data;
                m_bi = 0;
            end
            m_src = w; m_last = w; m_bv = 1;
        end else if (br) begin
            m_bv = 0;
        end
    endtask

    // Inputs change on the falling edge; readies sampled before the rising edge,
    // registered outputs sampled 1 time unit after it.
    task automatic cyc(input logic v0, input logic [7:0] d0,
                       input logic v1, input logic [7:0] d1, input logic br);
        @(negedge clk);
        req0_valid = v0; req0_data = d0;
        req1_valid = v1; req1_data = d1;
        bus_ready  = br;
        #1;
        s_r0 = req0_ready;
        s_r1 = req1_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        req0_valid = 0; req1_valid = 0; bus_ready = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".r0"},  16'(s_r0),      16'(m_r0));
        chk({tag, ".r1"},  16'(s_r1),      16'(m_r1));
        chk({tag, ".bv"},  16'(bus_valid), 16'(m_bv));
        chk({tag, ".bd"},  16'(bus_data),  16'(m_bd));
        chk({tag, ".bi"},  16'(bus_inv),   16'(m_bi));
        chk({tag, ".src"}, 16'(bus_src),   16'(m_src));
`ifdef BIC_STATS_EN
        chk({tag, ".sav"}, sav_count,      16'(m_sav));
`endif
    endtask

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       br;
        logic       r0, r1, bv;
        logic [7:0] bd;
        logic       bi, src;
        int         sav;
    } vec_t;

    vec_t tbl[14];

    initial begin
        //            v0 d0     v1 d1     br  r0 r1 bv bd     bi src sav
        tbl[0]  = '{1, 8'hFF, 0, 8'h00, 1,  1, 0, 1, 8'h00, 1, 0,  8};
        tbl[1]  = '{1, 8'h0F, 0, 8'h00, 1,  1, 0, 1, 8'h0F, 0, 0,  8};
        tbl[2]  = '{1, 8'hAA, 1, 8'h55, 1,  0, 1, 1, 8'h55, 0, 1,  8};
        tbl[3]  = '{1, 8'hAA, 1, 8'h33, 1,  1, 0, 1, 8'h55, 1, 0, 16};
        tbl[4]  = '{1, 8'h11, 1, 8'hF0, 0,  0, 0, 1, 8'h55, 1, 0, 16};
        tbl[5]  = '{1, 8'h11, 1, 8'hF0, 0,  0, 0, 1, 8'h55, 1, 0, 16};
        tbl[6]  = '{1, 8'h11, 1, 8'hF0, 0,  0, 0, 1, 8'h55, 1, 0, 16};
        tbl[7]  = '{1, 8'h11, 1, 8'hF0, 1,  0, 1, 1, 8'hF0, 0, 1, 16};
        tbl[8]  = '{0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'hF0, 0, 1, 16};
        tbl[9]  = '{0, 8'h00, 0, 8'h00, 0,  0, 0, 0, 8'hF0, 0, 1, 16};
        tbl[10] = '{0, 8'h00, 1, 8'h0F, 0,  0, 1, 1, 8'hF0, 1, 1, 24};
        tbl[11] = '{1, 8'hF1, 0, 8'h00, 1,  1, 0, 1, 8'hF1, 0, 0, 24};
        tbl[12] = '{1, 8'hEE, 0, 8'h00, 1,  1, 0, 1, 8'h11, 1, 0, 26};
        tbl[13] = '{0, 8'h00, 0, 8'h00, 1,  0, 0, 0, 8'h11, 1, 0, 26};

        rst = 1; req0_valid = 0; req1_valid = 0; req0_data = '0; req1_data = '0; bus_ready = 0;
        #2;
        rst = 0;
        req0_valid = 1;
        #1;
        chk("rst.bv",  16'(bus_valid),  16'd0);
        chk("rst.bd",  16'(bus_data),   16'd0);
        chk("rst.bi",  16'(bus_inv),    16'd0);
        chk("rst.src", 16'(bus_src),    16'd0);
        chk("rst.r0",  16'(req0_ready), 16'd0);
`ifdef BIC_STATS_EN
        chk("rst.sav", sav_count,       16'd0);
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        #1;
        chk("post_rst.r0", 16'(req0_ready), 16'd1);
        req0_valid = 0;
        model_reset();

        // Vector table
        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].br);
            chk($sformatf("vec%0d.r0", i),  16'(s_r0),      16'(tbl[i].r0));
            chk($sformatf("vec%0d.r1", i),  16'(s_r1),      16'(tbl[i].r1));
            chk($sformatf("vec%0d.bv", i),  16'(bus_valid), 16'(tbl[i].bv));
            chk($sformatf("vec%0d.bd", i),  16'(bus_data),  16'(tbl[i].bd));
            chk($sformatf("vec%0d.bi", i),  16'(bus_inv),   16'(tbl[i].bi));
            chk($sformatf("vec%0d.src", i), 16'(bus_src),   16'(tbl[i].src));
`ifdef BIC_STATS_EN
            chk($sformatf("vec%0d.sav", i), sav_count,      16'(tbl[i].sav));
`endif
        end

        // Both requesters valid every cycle: strict alternation starting with 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 8'($urandom), 1, 8'($urandom), 1);
            chk($sformatf("rr%0d.src", i), 16'(bus_src),   16'(i % 2));
            chk($sformatf("rr%0d.bv", i),  16'(bus_valid), 16'd1);
            chk($sformatf("rr%0d.rdy", i), 16'({s_r1, s_r0}), (i % 2 == 0) ? 16'd1 : 16'd2);
        end

        // Asynchronous reset while FULL and stalled
        do_reset();
        cyc(1, 8'h5A, 0, 8'h00, 0);
        chk("arst.pre_bv", 16'(bus_valid), 16'd1);
        chk("arst.pre_bd", 16'(bus_data),  16'h5A);
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        chk("arst.bv", 16'(bus_valid),  16'd0);
        chk("arst.bd", 16'(bus_data),   16'd0);
        chk("arst.r0", 16'(req0_ready), 16'd0);
        req0_valid = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        model_reset();
        cyc(0, 8'h00, 1, 8'h3C, 1);
        chk("arst.r1",  16'(s_r1),     16'd1);
        chk("arst.src", 16'(bus_src),  16'd1);
        chk("arst.bd2", 16'(bus_data), 16'h3C);
        chk("arst.bi2", 16'(bus_inv),  16'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic       v0, v1, br;
            logic [7:0] d0, d1;
            v0 = 1'($urandom_range(0, 1));
            v1 = 1'($urandom_range(0, 1));
            br = ($urandom_range(0, 9) < 7);
            d0 = 8'($urandom);
            d1 = 8'($urandom);
            model_step(v0, d0, v1, d1, br);
            cyc(v0, d0, v1, d1, br);
            chk_model($sformatf("rnd%0d", i));
        end

`ifdef BIC_STATS_EN
        // Saturation: each inverting accept adds 8, so the counter hits the ceiling
        do_reset();
        for (int i = 0; i < 16500; i++) begin
            logic [7:0] d;
            d = (i % 2 == 0) ? 8'hFF : 8'h00;
            model_step(1, d, 0, 8'h00, 1);
            cyc(1, d, 0, 8'h00, 1);
        end
        chk("sat.model", sav_count, 16'(m_sav));
        chk("sat.max",   sav_count, 16'hFFFF);
        model_step(1, 8'hFF, 0, 8'h00, 1);
        cyc(1, 8'hFF, 0, 8'h00, 1);
        chk("sat.hold",  sav_count, 16'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
